// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-block write port and tracks pending destinations.
// Optional macro REGSCHED_RR_EN: round-robin on conflict (default build: load source always wins a conflict).
module regfile_write_scheduler #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 16
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          AluReq,
  input  logic [AW-1:0] AluRw,
  input  logic [DW-1:0] AluData,
  output logic          AluAck,
  input  logic          MemReq,
  input  logic [AW-1:0] MemRw,
  input  logic [DW-1:0] MemData,
  output logic          MemAck,
  input  logic          ResvValid,
  input  logic [AW-1:0] ResvRw,
  input  logic [AW-1:0] Rs1In,
  input  logic [AW-1:0] Rs2In,
  output logic [AW-1:0] RwIn,
  output logic          We,
  output logic [DW-1:0] WData,
  output logic          Stall,
  output logic          Idle
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e             last_gnt;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             mem_pri_c;
  logic             alu_gnt_c;
  logic             mem_gnt_c;
  logic             gnt_c;
  logic [AW-1:0]    gnt_rw_c;
  logic [DW-1:0]    gnt_data_c;

`ifdef REGSCHED_RR_EN
  // Conflict goes to whichever source was not granted last; reset value MEM hands the first conflict to ALU.
  assign mem_pri_c = (last_gnt == SRC_ALU);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = (last_gnt == SRC_MEM);
  assign mem_pri_c       = 1'b1;
`endif

  // Grant selection; no grant while reset is asserted.
  always_comb begin
    alu_gnt_c = 1'b0;
    mem_gnt_c = 1'b0;
    if (nReset) begin
      if (AluReq && MemReq) begin
        mem_gnt_c = mem_pri_c;
        alu_gnt_c = !mem_pri_c;
      end else begin
        alu_gnt_c = AluReq;
        mem_gnt_c = MemReq;
      end
    end
  end

  assign gnt_c      = alu_gnt_c | mem_gnt_c;
  assign gnt_rw_c   = mem_gnt_c ? MemRw : AluRw;
  assign gnt_data_c = mem_gnt_c ? MemData : AluData;
  assign AluAck     = alu_gnt_c;
  assign MemAck     = mem_gnt_c;

  // Clear applied before set so a reserve on the same edge as a grant keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (gnt_c) begin
      pending_nxt[gnt_rw_c] = 1'b0;
    end
    if (ResvValid) begin
      pending_nxt[ResvRw] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      We       <= 1'b0;
      RwIn     <= '0;
      WData    <= '0;
      pending  <= '0;
      last_gnt <= SRC_MEM;
    end else begin
      We      <= gnt_c;
      pending <= pending_nxt;
      if (gnt_c) begin
        RwIn     <= gnt_rw_c;
        WData    <= gnt_data_c;
        last_gnt <= mem_gnt_c ? SRC_MEM : SRC_ALU;
      end
    end
  end

  assign Stall = pending[Rs1In] | pending[Rs2In];
  assign Idle  = ~(|pending) & ~AluReq & ~MemReq & ~We;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler; expectations follow REGSCHED_RR_EN when defined.
module tb_regfile_write_scheduler;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          Clock = 1'b0;
  logic          nReset;
  logic          AluReq, MemReq, ResvValid;
  logic [AW-1:0] AluRw, MemRw, ResvRw, Rs1In, Rs2In;
  logic [DW-1:0] AluData, MemData;
  logic          AluAck, MemAck, We, Stall, Idle;
  logic [AW-1:0] RwIn;
  logic [DW-1:0] WData;

  int n_checks = 0;
  int n_fail   = 0;

  logic          first_is_alu;
  logic [AW-1:0] first_rw, second_rw;
  logic [DW-1:0] first_data, second_data;

  always #5 Clock = ~Clock;

  regfile_write_scheduler #(.NREGS(8), .AW(AW), .DW(DW)) dut (
    .Clock(Clock), .nReset(nReset),
    .AluReq(AluReq), .AluRw(AluRw), .AluData(AluData), .AluAck(AluAck),
    .MemReq(MemReq), .MemRw(MemRw), .MemData(MemData), .MemAck(MemAck),
    .ResvValid(ResvValid), .ResvRw(ResvRw), .Rs1In(Rs1In), .Rs2In(Rs2In),
    .RwIn(RwIn), .We(We), .WData(WData), .Stall(Stall), .Idle(Idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef REGSCHED_RR_EN
    first_is_alu = 1'b1;
`else
    first_is_alu = 1'b0;
`endif
    if (first_is_alu) begin
      first_rw = 3'd2; first_data = 16'haaaa; second_rw = 3'd6; second_data = 16'hbbbb;
    end else begin
      first_rw = 3'd6; first_data = 16'hbbbb; second_rw = 3'd2; second_data = 16'haaaa;
    end

    // Reset held with both requests up
    nReset = 1'b0; ResvValid = 1'b0; ResvRw = '0; Rs1In = '0; Rs2In = '0;
    AluReq = 1'b1; AluRw = 3'd2; AluData = 16'haaaa;
    MemReq = 1'b1; MemRw = 3'd6; MemData = 16'hbbbb;
    #2;
    chk("rst_aluack", 32'(AluAck), 32'(1'b0));
    chk("rst_memack", 32'(MemAck), 32'(1'b0));
    chk("rst_we", 32'(We), 32'(1'b0));
    chk("rst_stall", 32'(Stall), 32'(1'b0));
    chk("rst_idle", 32'(Idle), 32'(1'b0));
    @(negedge Clock); @(negedge Clock);
    chk("rst_we_hold", 32'(We), 32'(1'b0));
    chk("rst_rwin", 32'(RwIn), 32'(3'd0));
    chk("rst_wdata", 32'(WData), 32'(16'h0));

    // Conflict straight out of reset
    nReset = 1'b1; #1;
    chk("cf_aluack", 32'(AluAck), 32'(first_is_alu));
    chk("cf_memack", 32'(MemAck), 32'(!first_is_alu));
    @(negedge Clock);
    chk("cf_we1", 32'(We), 32'(1'b1));
    chk("cf_rw1", 32'(RwIn), 32'(first_rw));
    chk("cf_data1", 32'(WData), 32'(first_data));
    if (first_is_alu) AluReq = 1'b0; else MemReq = 1'b0;
    #1;
    chk("cf_aluack2", 32'(AluAck), 32'(!first_is_alu));
    chk("cf_memack2", 32'(MemAck), 32'(first_is_alu));
    @(negedge Clock);
    chk("cf_we2", 32'(We), 32'(1'b1));
    chk("cf_rw2", 32'(RwIn), 32'(second_rw));
    chk("cf_data2", 32'(WData), 32'(second_data));
    AluReq = 1'b0; MemReq = 1'b0;
    @(negedge Clock);
    chk("cf_we3", 32'(We), 32'(1'b0));

    // Single ALU writeback
    AluReq = 1'b1; AluRw = 3'd3; AluData = 16'h1234; #1;
    chk("alu_ack", 32'(AluAck), 32'(1'b1));
    chk("alu_memack", 32'(MemAck), 32'(1'b0));
    @(negedge Clock);
    AluReq = 1'b0; #1;
    chk("alu_we", 32'(We), 32'(1'b1));
    chk("alu_rw", 32'(RwIn), 32'(3'd3));
    chk("alu_data", 32'(WData), 32'(16'h1234));
    chk("alu_ack_drop", 32'(AluAck), 32'(1'b0));
    @(negedge Clock);
    chk("alu_we_low", 32'(We), 32'(1'b0));
    chk("idle_quiet", 32'(Idle), 32'(1'b1));

    // Reserve r5, stall on Rs1, cleared by load
    ResvValid = 1'b1; ResvRw = 3'd5;
    @(negedge Clock);
    ResvValid = 1'b0; Rs1In = 3'd5; #1;
    chk("r5_stall", 32'(Stall), 32'(1'b1));
    chk("r5_idle", 32'(Idle), 32'(1'b0));
    MemReq = 1'b1; MemRw = 3'd5; MemData = 16'h5555; #1;
    chk("r5_memack", 32'(MemAck), 32'(1'b1));
    chk("r5_stall_ack", 32'(Stall), 32'(1'b1));
    @(negedge Clock);
    MemReq = 1'b0; #1;
    chk("r5_stall_clr", 32'(Stall), 32'(1'b0));
    chk("r5_we", 32'(We), 32'(1'b1));
    chk("r5_rw", 32'(RwIn), 32'(3'd5));
    chk("r5_data", 32'(WData), 32'(16'h5555));

    // Reserve and grant to r4 on the same edge: reserve wins
    ResvValid = 1'b1; ResvRw = 3'd4; AluReq = 1'b1; AluRw = 3'd4; AluData = 16'h0444; #1;
    chk("r4_ack", 32'(AluAck), 32'(1'b1));
    @(negedge Clock);
    ResvValid = 1'b0; AluReq = 1'b0; Rs1In = 3'd0; Rs2In = 3'd4; #1;
    chk("r4_stall", 32'(Stall), 32'(1'b1));
    chk("r4_we", 32'(We), 32'(1'b1));
    AluReq = 1'b1; AluData = 16'h0445;
    @(negedge Clock);
    AluReq = 1'b0; #1;
    chk("r4_stall_clr", 32'(Stall), 32'(1'b0));
    chk("r4_data2", 32'(WData), 32'(16'h0445));

    // Both sources to r7; last grant was ALU so MEM goes first in either build
    ResvValid = 1'b1; ResvRw = 3'd7;
    @(negedge Clock);
    ResvValid = 1'b0; Rs2In = 3'd7;
    AluReq = 1'b1; AluRw = 3'd7; AluData = 16'h7a7a;
    MemReq = 1'b1; MemRw = 3'd7; MemData = 16'h7b7b; #1;
    chk("r7_memack", 32'(MemAck), 32'(1'b1));
    chk("r7_aluack", 32'(AluAck), 32'(1'b0));
    @(negedge Clock);
    MemReq = 1'b0; #1;
    chk("r7_data1", 32'(WData), 32'(16'h7b7b));
    chk("r7_aluack2", 32'(AluAck), 32'(1'b1));
    @(negedge Clock);
    AluReq = 1'b0; #1;
    chk("r7_we2", 32'(We), 32'(1'b1));
    chk("r7_data2", 32'(WData), 32'(16'h7a7a));
    chk("r7_stall", 32'(Stall), 32'(1'b0));

    // Reset mid-operation with pending r1 and a write in flight
    ResvValid = 1'b1; ResvRw = 3'd1;
    @(negedge Clock);
    ResvValid = 1'b0; Rs1In = 3'd1; Rs2In = 3'd0;
    AluReq = 1'b1; AluRw = 3'd2; AluData = 16'h2222; #1;
    chk("mr_stall", 32'(Stall), 32'(1'b1));
    @(negedge Clock);
    AluReq = 1'b0;
    MemReq = 1'b1; MemRw = 3'd1; MemData = 16'h1111; #1;
    chk("mr_we_inflight", 32'(We), 32'(1'b1));
    nReset = 1'b0; #1;
    chk("mr_we_cancel", 32'(We), 32'(1'b0));
    chk("mr_stall_lost", 32'(Stall), 32'(1'b0));
    chk("mr_memack_rst", 32'(MemAck), 32'(1'b0));
    @(negedge Clock);
    nReset = 1'b1; #1;
    chk("mr_memack", 32'(MemAck), 32'(1'b1));
    @(negedge Clock);
    MemReq = 1'b0; #1;
    chk("mr_we", 32'(We), 32'(1'b1));
    chk("mr_rw", 32'(RwIn), 32'(3'd1));
    chk("mr_data", 32'(WData), 32'(16'h1111));
    @(negedge Clock);
    chk("mr_idle", 32'(Idle), 32'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
